// File: rtl/sync_arb_if.sv
// Handshake bundle between the four request sources, the synchronizer channel and sync_arb.
// slave = arbiter view, master = driver (sources + channel) view.
interface sync_arb_if #(
    parameter int DATA_WIDTH = 8
);
    logic [3:0]              src_valid;
    logic [4*DATA_WIDTH-1:0] src_data;
    logic [3:0]              src_ready;
    logic                    v;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    f;
    logic                    d;
    logic [1:0]              rx_src;
    logic                    rx_src_vld;
    logic                    err;

    modport slave (
        input  src_valid, src_data, f, d,
        output src_ready, v, out_data, rx_src, rx_src_vld, err
    );

    modport master (
        output src_valid, src_data, f, d,
        input  src_ready, v, out_data, rx_src, rx_src_vld, err
    );
endinterface

// File: rtl/sync_arb.sv
// Purpose: 4-source round-robin arbiter feeding a synchronizer channel; tags in-flight words by source.
// Latency: request seen in IDLE -> word on channel next cycle, src_ready on the cycle it is taken.
// Backpressure: f holds the word (HOLD); a full tag FIFO blocks new selection. SYNC_ARB_PRIO_EN gives source 0 fixed priority.
module sync_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    sync_arb_if.slave   bus
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_q;
    logic                  v_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            win_q;
    logic [1:0]            lg_q;
    logic                  err_q;

    logic [1:0]            tag_q [TAG_DEPTH];
    logic [PW-1:0]         wr_q;
    logic [PW-1:0]         rd_q;
    logic [CW-1:0]         cnt_q;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  accept;
    logic                  pop;
    logic                  sel_found;
    logic [1:0]            sel_idx;
    logic [1:0]            cand;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(TAG_DEPTH));
    assign accept     = v_q & ~bus.f;
    assign pop        = bus.d & ~fifo_empty;

    // Winner search begins one past the last granted source.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = lg_q;
`ifdef SYNC_ARB_PRIO_EN
        if (bus.src_valid[0]) begin
            sel_found = 1'b1;
            sel_idx   = 2'd0;
        end
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
            if (!sel_found && bus.src_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            cand = cand + 2'd1;
            if (!sel_found && bus.src_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            v_q     <= 1'b0;
            data_q  <= '0;
            win_q   <= 2'd0;
            lg_q    <= 2'd3;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (bus.d && fifo_empty) begin
                err_q <= 1'b1;
            end

            if (accept) begin
                tag_q[wr_q] <= win_q;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (sel_found && !fifo_full) begin
                        state_q <= SEND;
                        v_q     <= 1'b1;
                        win_q   <= sel_idx;
                        data_q  <= bus.src_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                SEND, HOLD: begin
                    if (accept) begin
                        state_q <= IDLE;
                        v_q     <= 1'b0;
`ifdef SYNC_ARB_PRIO_EN
                        if (win_q != 2'd0) begin
                            lg_q <= win_q;
                        end
`else
                        lg_q <= win_q;
`endif
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    v_q     <= 1'b0;
                end
            endcase
        end
    end

    // Handshake pulses are suppressed while reset is asserted so a dropped word never looks taken.
    assign bus.src_ready  = (accept && !reset) ? (4'b0001 << win_q) : 4'b0000;
    assign bus.v          = v_q;
    assign bus.out_data   = data_q;
    assign bus.rx_src     = tag_q[rd_q];
    assign bus.rx_src_vld = bus.d & ~fifo_empty & ~reset;
    assign bus.err        = err_q;
endmodule

// File: doc/sync_arb.md
SYNC_ARB -- requirements
Module: sync_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each source word and of the channel word.
REQ-002 Parameter TAG_DEPTH, default 4 (power of two, 2..16), number of in-flight words tracked.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 src_valid  input  4  per-source request; source i holds its word until it sees src_ready[i].
REQ-006 src_data  input  4*DATA_WIDTH  source i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 src_ready  output  4  one-hot pulse; word of source i accepted into the channel this cycle.
REQ-008 v  output  1  valid to the synchronizer channel transmitter.
REQ-009 out_data  output  DATA_WIDTH  word presented to the channel; stable while v=1.
REQ-010 f  input  1  channel transmitter full; word not taken while f=1.
REQ-011 d  input  1  one-cycle pulse from the channel receiver; one word delivered.
REQ-012 rx_src  output  2  source index of the word delivered with the current d pulse.
REQ-013 rx_src_vld  output  1  high in a cycle with d=1 and a non-empty tag FIFO.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 FSM states IDLE, SEND, HOLD; encoding free.
REQ-016 IDLE: if any src_valid=1 and tag FIFO not full, select winner, latch its index and word, go to SEND next cycle.
REQ-017 Arbitration round-robin: search starts at (last_grant+1) mod 4; last_grant resets to 3 so source 0 wins first.
REQ-018 SEND/HOLD: v=1, out_data=latched word; acceptance = v & ~f.
REQ-019 On acceptance: src_ready[winner]=1 for exactly that cycle, tag push of winner index, last_grant=winner; go to IDLE.
REQ-020 SEND with f=1: go to HOLD; remain in HOLD with word and winner unchanged until f=0.
REQ-021 Latency: src_valid rising in IDLE with f=0 -> src_ready pulse 2 cycles later (IDLE->SEND->accept).
REQ-022 src_valid of the winner dropping in SEND/HOLD does not abort; latched word is still sent.
REQ-023 Tag FIFO: TAG_DEPTH entries of 2 bits, push on acceptance, pop on d=1 when non-empty.
REQ-024 rx_src = head entry combinationally; rx_src_vld = d & ~empty.
REQ-025 Push and pop in same cycle: occupancy unchanged, both pointers advance, wrap modulo TAG_DEPTH.
REQ-026 Tag FIFO full: no new selection from IDLE; SEND/HOLD in progress already reserved its slot and completes.
REQ-027 d=1 with FIFO empty: no pop, rx_src_vld=0, err set to 1 and held until reset.
REQ-028 v is never high outside SEND/HOLD; src_ready never has more than one bit set.

Reset
REQ-029 reset=1 at a clock edge: state IDLE, v=0, out_data=0, src_ready=0, tag FIFO empty, rx_src_vld=0, err=0, last_grant=3.
REQ-030 reset asserted in SEND/HOLD: latched word dropped, no src_ready pulse, no tag push.
REQ-031 reset overrides all simultaneous events, including d and acceptance, in the same cycle.

Configuration
REQ-032 Macro SYNC_ARB_PRIO_EN defined: source 0 wins whenever src_valid[0]=1; sources 1..3 round-robin among themselves, last_grant updated only for 1..3.
REQ-033 Macro SYNC_ARB_PRIO_EN undefined: pure 4-way round-robin per REQ-017; all other behaviour identical.

Verification
REQ-034 Single source: src_valid=0001, data 0xA5, f=0 -> v=1 out_data=0xA5 in cycle 2, src_ready=0001 same cycle; d later -> rx_src=0, rx_src_vld=1.
REQ-035 All four valid continuously, f=0, no prio macro -> grant order 0,1,2,3,0; each src_ready pulse one cycle, 2 cycles apart.
REQ-036 f=1 held 5 cycles during SEND -> v=1 and out_data constant for 6 cycles, single src_ready when f drops.
REQ-037 TAG_DEPTH=4, d never pulses, sources valid -> exactly 4 acceptances, then v stays 0; one d pulse -> one further acceptance.
REQ-038 d pulse with empty FIFO -> rx_src_vld=0, err=1 until reset; reset in HOLD -> v=0 next cycle, no src_ready.
REQ-039 SYNC_ARB_PRIO_EN defined, src_valid=1111 continuously -> source 0 granted every acceptance; drop src_valid[0] -> order 1,2,3,1.
